// File: rtl/itf_req_arb.sv
// ITF port arbiter: registered, aged round-robin selection among read/write ports,
// holding one grant until ITF reports the transfer done.
module itf_req_arb #(
  parameter int unsigned NUM_RDPORT = 2,
  parameter int unsigned NUM_WRPORT = 3,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned AGE_WIDTH  = 8,
  parameter int unsigned AGE_LIMIT  = 200,
  localparam int unsigned NUM_PORT  = NUM_RDPORT + NUM_WRPORT,
  localparam int unsigned PW        = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PORT-1:0]          TOPARB_Urgent,
  input  logic [ADDR_WIDTH*NUM_PORT-1:0] TOPARB_ReqNum,
  output logic                         ARBITF_GntVld,
  output logic [PW-1:0]                ARBITF_GntPort,
  output logic [ADDR_WIDTH-1:0]        ARBITF_GntNum,
  output logic                         ARBITF_GntRd,
  input  logic                         ITFARB_GntRdy,
  input  logic                         ITFARB_Done,
  output logic                         ARB_Busy
);

  typedef enum logic [1:0] {StIdle, StGrant, StBusy} arbState_t;

  arbState_t             stateQ, stateD;
  logic [PW-1:0]         rrPtr;
  logic [AGE_WIDTH-1:0]  age [NUM_PORT];
  logic [PW-1:0]         gntPortQ;
  logic [ADDR_WIDTH-1:0] gntNumQ;
  logic                  gntRdQ;

  logic [NUM_PORT-1:0]   eligible, agedVec, urgVec, classVec;
  logic                  winFound;
  logic [PW-1:0]         winIdx;
  logic                  accept;

  always_comb begin
    for (int j = 0; j < NUM_PORT; j++) begin
      eligible[j] = (TOPARB_ReqNum[ADDR_WIDTH*j +: ADDR_WIDTH] != '0);
      agedVec[j]  = eligible[j] && (age[j] == AGE_WIDTH'(AGE_LIMIT));
      urgVec[j]   = eligible[j] && TOPARB_Urgent[j];
    end
  end

  // Highest non-empty class wins; round-robin scan from rrPtr within that class.
  always_comb begin
    int unsigned idx;
    classVec = (|agedVec) ? agedVec : ((|urgVec) ? urgVec : eligible);
    winFound = 1'b0;
    winIdx   = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_PORT; k++) begin
      idx = 32'(rrPtr) + k;
      if (idx >= NUM_PORT) idx = idx - NUM_PORT;
      if (!winFound && classVec[idx]) begin
        winFound = 1'b1;
        winIdx   = PW'(idx);
      end
    end
  end

  assign accept = (stateQ == StGrant) && ITFARB_GntRdy;

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (winFound) stateD = StGrant;
      StGrant: if (ITFARB_GntRdy) stateD = StBusy;
      StBusy:  if (ITFARB_Done) stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= StIdle;
      rrPtr    <= '0;
      gntPortQ <= '0;
      gntNumQ  <= '0;
      gntRdQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (stateQ == StIdle && winFound) begin
        gntPortQ <= winIdx;
        gntNumQ  <= TOPARB_ReqNum[ADDR_WIDTH*winIdx +: ADDR_WIDTH];
        gntRdQ   <= (32'(winIdx) >= NUM_WRPORT);
      end
      if (stateQ == StBusy && ITFARB_Done) begin
        rrPtr <= (gntPortQ == PW'(NUM_PORT - 1)) ? '0 : gntPortQ + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_PORT; j++) age[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_PORT; j++) begin
        if (!eligible[j]) begin
          age[j] <= '0;
        end else if (accept && gntPortQ == PW'(j)) begin
          age[j] <= '0;
        end else if (age[j] != AGE_WIDTH'(AGE_LIMIT)) begin
          age[j] <= age[j] + 1'b1;
        end
      end
    end
  end

  assign ARBITF_GntVld  = (stateQ == StGrant);
  assign ARB_Busy       = (stateQ != StIdle);
  assign ARBITF_GntPort = gntPortQ;
  assign ARBITF_GntNum  = gntNumQ;
  assign ARBITF_GntRd   = gntRdQ;

endmodule

// File: tb/tb_itf_req_arb.sv
// Directed bench for itf_req_arb; a second instance with AGE_LIMIT=4 covers aging.
module tb_itf_req_arb;

  localparam int unsigned NP = 5;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] urgent;
  logic [AW*NP-1:0] reqNum;
  logic          gntRdy, done;

  logic          gVld, gRd, gBusy, aVld, aRd, aBusy;
  logic [2:0]    gPort, aPort;
  logic [AW-1:0] gNum, aNum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  itf_req_arb dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .TOPARB_Urgent (urgent),
    .TOPARB_ReqNum (reqNum),
    .ARBITF_GntVld (gVld),
    .ARBITF_GntPort(gPort),
    .ARBITF_GntNum (gNum),
    .ARBITF_GntRd  (gRd),
    .ITFARB_GntRdy (gntRdy),
    .ITFARB_Done   (done),
    .ARB_Busy      (gBusy)
  );

  itf_req_arb #(.AGE_LIMIT(4)) dutAge (
    .clk           (clk),
    .rst_n         (rst_n),
    .TOPARB_Urgent (urgent),
    .TOPARB_ReqNum (reqNum),
    .ARBITF_GntVld (aVld),
    .ARBITF_GntPort(aPort),
    .ARBITF_GntNum (aNum),
    .ARBITF_GntRd  (aRd),
    .ITFARB_GntRdy (gntRdy),
    .ITFARB_Done   (done),
    .ARB_Busy      (aBusy)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int j, input logic [AW-1:0] v);
    reqNum[AW*j +: AW] = v;
  endtask

  // Waits for a grant, checks it, accepts it and completes it with Done one cycle later.
  task automatic serve(input bit useAge, input int expPort, input int expNum, input string tag);
    int n = 0;
    while (!(useAge ? aVld : gVld) && n < 20) begin
      tick();
      n++;
    end
    checkVal({tag, "_vld"},  useAge ? aVld : gVld, 1);
    checkVal({tag, "_port"}, useAge ? aPort : gPort, expPort);
    checkVal({tag, "_num"},  useAge ? aNum : gNum, expNum);
    checkVal({tag, "_rd"},   useAge ? aRd : gRd, (expPort >= 3) ? 1 : 0);
    tick();
    if (useAge) checkVal({tag, "_ageClr"}, dutAge.age[expPort], 0);
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    urgent = '0;
    reqNum = '0;
    gntRdy = 1'b0;
    done   = 1'b0;
    tick();
    tick();
    checkVal("rst_vld", gVld, 0);
    checkVal("rst_busy", gBusy, 0);
    checkVal("rst_port", gPort, 0);
    checkVal("rst_num", gNum, 0);
    checkVal("rst_rd", gRd, 0);
    rst_n = 1'b1;

    // Single request with one-cycle latency
    setReq(2, 64);
    gntRdy = 1'b1;
    checkVal("single_noComb", gVld, 0);
    tick();
    checkVal("single_vld", gVld, 1);
    checkVal("single_port", gPort, 2);
    checkVal("single_num", gNum, 64);
    checkVal("single_rd", gRd, 0);
    tick();
    checkVal("single_accDrop", gVld, 0);
    checkVal("single_busy", gBusy, 1);
    setReq(2, 0);
    repeat (8) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    checkVal("single_rrPtr", dut.rrPtr, 3);
    checkVal("single_idle", gBusy, 0);
    checkVal("single_holdPort", gPort, 2);
    tick();
    checkVal("single_noRegrant", gVld, 0);

    // Round-robin from rr_ptr=0
    rst_n = 1'b0;
    for (int j = 0; j < NP; j++) setReq(j, 8);
    tick();
    rst_n = 1'b1;
    serve(0, 0, 8, "rr0");
    serve(0, 1, 8, "rr1");
    serve(0, 2, 8, "rr2");
    serve(0, 3, 8, "rr3");
    serve(0, 4, 8, "rr4");
    serve(0, 0, 8, "rr5");
    rst_n  = 1'b0;
    reqNum = '0;
    tick();
    rst_n = 1'b1;

    // Urgent override
    setReq(0, 5);
    setReq(3, 7);
    urgent[3] = 1'b1;
    serve(0, 3, 7, "urg");
    urgent[3] = 1'b0;
    setReq(3, 0);
    serve(0, 0, 5, "urgClr");
    setReq(0, 0);

    // Handshake hold with ReqNum dropping and stray Done pulses
    gntRdy = 1'b0;
    setReq(1, 9);
    tick();
    checkVal("hold_vld0", gVld, 1);
    checkVal("hold_port0", gPort, 1);
    setReq(1, 0);
    for (int i = 0; i < 20; i++) begin
      done = (i % 3 == 0);
      tick();
      checkVal("hold_vld", gVld, 1);
      checkVal("hold_port", gPort, 1);
      checkVal("hold_num", gNum, 9);
      checkVal("hold_busy", gBusy, 1);
    end
    done   = 1'b0;
    gntRdy = 1'b1;
    tick();
    checkVal("hold_accVld", gVld, 0);
    checkVal("hold_accBusy", gBusy, 1);
    checkVal("hold_accPort", gPort, 1);
    done = 1'b1;
    tick();
    done = 1'b0;
    checkVal("hold_idle", gBusy, 0);
    checkVal("hold_rrPtr", dut.rrPtr, 2);

    // Reset mid-transfer
    setReq(4, 3);
    tick();
    tick();
    checkVal("mid_busy", gBusy, 1);
    rst_n = 1'b0;
    #1;
    checkVal("mid_rstVld", gVld, 0);
    checkVal("mid_rstBusy", gBusy, 0);
    checkVal("mid_rstPort", gPort, 0);
    checkVal("mid_rstNum", gNum, 0);
    setReq(4, 0);
    setReq(1, 6);
    setReq(3, 6);
    tick();
    checkVal("mid_rstHold", gVld, 0);
    rst_n = 1'b1;
    tick();
    checkVal("mid_relVld", gVld, 1);
    checkVal("mid_relPort", gPort, 1);

    // Aging on the AGE_LIMIT=4 instance
    rst_n  = 1'b0;
    reqNum = '0;
    urgent = '0;
    setReq(1, 10);
    setReq(4, 10);
    urgent[1] = 1'b1;
    tick();
    rst_n = 1'b1;
    serve(1, 1, 10, "age1a");
    serve(1, 1, 10, "age1b");
    serve(1, 4, 10, "age4");
    serve(1, 1, 10, "age1c");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/itf_req_arb.md
# itf_req_arb

Port arbiter for the off-chip interface (ITF). It watches the request counts and empty/full flags of all on-chip read and write ports and issues one grant at a time: port index plus transfer length. It holds the grant until ITF reports the transfer finished. It replaces combinational first-match selection with registered, aged round-robin arbitration so that no port starves.

## Interface
- NUM_RDPORT, 2, number of read-from-TOP ports; these occupy indices NUM_WRPORT..NUM_PORT-1
- NUM_WRPORT, 3, number of write-to-TOP ports; these occupy indices 0..NUM_WRPORT-1
- ADDR_WIDTH, 16, width of each request count
- AGE_WIDTH, 8, width of each per-port age counter
- AGE_LIMIT, 200, age value at which a waiting port becomes top priority; must be 1..2^AGE_WIDTH-1
- Derived: NUM_PORT = NUM_RDPORT+NUM_WRPORT; PW = $clog2(NUM_PORT)

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- TOPARB_Urgent  in  NUM_PORT  per-port empty (write port) or full (read port) flag; raises priority
- TOPARB_ReqNum  in  ADDR_WIDTH*NUM_PORT  per-port pending transfer count; port j occupies bits [ADDR_WIDTH*j +: ADDR_WIDTH]
- ARBITF_GntVld  out  1  grant valid
- ARBITF_GntPort  out  PW  granted port index
- ARBITF_GntNum  out  ADDR_WIDTH  request count latched at selection
- ARBITF_GntRd  out  1  1 when GntPort >= NUM_WRPORT (read from TOP), else 0
- ITFARB_GntRdy  in  1  ITF accepts the grant
- ITFARB_Done  in  1  one-cycle pulse: granted transfer completed
- ARB_Busy  out  1  high in GRANT and BUSY states

## Operation
- Eligibility: port j is eligible iff ReqNum[j] != 0. Urgent[j] with ReqNum[j]==0 is ignored.
- Priority classes, highest first:
  - aged: age[j] == AGE_LIMIT
  - urgent
  - plain eligible
- Within a class, the winner is the first eligible port found scanning round-robin from rr_ptr upward, wrapping NUM_PORT-1 -> 0.
- FSM states: IDLE, GRANT, BUSY.
  - IDLE -> GRANT when any port is eligible. The winner's index and ReqNum are registered into GntPort and GntNum on this edge.
  - GRANT -> BUSY on GntVld & GntRdy.
  - BUSY -> IDLE on Done. On the same edge rr_ptr <= GntPort+1; the value NUM_PORT wraps to 0.
- Done is ignored in IDLE and GRANT. GntRdy is ignored outside GRANT.
- The grant is stable: GntPort, GntNum and GntRd do not change from the IDLE->GRANT edge until the next IDLE->GRANT edge. This holds even if the inputs change in the meantime.
- Age counters, per port, updated every cycle in every state:
  - Cleared when the port is not eligible.
  - Cleared on the GntVld & GntRdy edge for the granted port.
  - Otherwise incremented, saturating at AGE_LIMIT.
- Ties among aged ports are resolved by the round-robin scan.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, all ages=0
  - GntVld=0, GntPort=0, GntNum=0, GntRd=0, Busy=0
- Latency: a port that becomes eligible in cycle N, while the FSM is in IDLE, sees GntVld=1 in cycle N+1. This is a registered decision with no combinational input-to-GntVld path.
- GntVld stays high until GntRdy is sampled high. It falls the cycle after acceptance.
- After Done in cycle M, the FSM is in IDLE in M+1. The earliest next GntVld is M+2.
- Reset asserted mid-operation: everything returns to reset values immediately. No grant survives reset.
- ReqNum dropping to 0 while in GRANT: the grant is not withdrawn and GntNum keeps its latched value.
- Only one grant can be outstanding at a time.

## Test plan
- Single request: ReqNum[2]=64, others 0; GntRdy=1; Done 10 cycles later.
  - Required: GntVld one cycle after ReqNum is applied, GntPort=2, GntNum=64, GntRd=0.
  - Required: rr_ptr=3 after Done.
- Round-robin: all five ports hold ReqNum=8, no Urgent, Done 1 cycle after each accept.
  - Required grant order: 0,1,2,3,4,0.
- Urgent override: ports 0 and 3 eligible with rr_ptr=0, Urgent[3]=1.
  - Required: GntPort=3, GntRd=1.
  - Then with Urgent[3]=0, ReqNum[3]=0, ReqNum[0] still set: GntPort=0.
- Aging: AGE_LIMIT=4; Urgent[1]=1 re-requested continuously; port 4 eligible and not urgent.
  - Required: port 4 is granted at the first IDLE decision after age[4] reaches 4.
  - Required: age[4] reads 0 the cycle after acceptance.
- Handshake hold: GntRdy held low 20 cycles while ReqNum[GntPort] changes to 0.
  - Required: GntVld, GntPort and GntNum stay constant throughout.
  - Required: Done pulses during GRANT are ignored and the FSM enters BUSY only after GntRdy.
- Reset mid-transfer: assert rst_n=0 while in BUSY.
  - Required: GntVld=0, Busy=0, GntPort=0 and GntNum=0 while reset is asserted.
  - Required: with one port eligible, the first grant comes 1 cycle after release, with the scan starting from rr_ptr=0.
